// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int ZERO_ADDR = 0;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_wr_sel.sv
// Priority match of one register address against all write ports.
// The highest-indexed enabled port that matches supplies the data.
module regfile_wr_sel #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 1
) (
  input  logic [AW-1:0]       addr_i,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  output logic                hit_o,
  output logic [XLEN-1:0]     data_o
);

  // NOTE: blocking assignments in combinational logic; defaults come first so
  // every path assigns both outputs and no latch is inferred.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int i = 0; i < NWR; i++) begin
      if (we_i[i] && (waddr_i[i*AW +: AW] == addr_i)) begin
        hit_o  = 1'b1;
        data_o = wdata_i[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional hardwired zero register, same-cycle
// write-to-read bypass and a per-register busy scoreboard for hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                set_en,
  input  logic [AW-1:0]       set_addr
);

  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_data [NREGS];

  for (genvar r = 0; r < NREGS; r++) begin : g_reg_sel
    regfile_wr_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_sel (
      .addr_i  (AW'(r)),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .hit_o   (wr_hit[r]),
      .data_o  (wr_data[r])
    );
  end

  // A set on the same register as a write wins: the new producer supersedes.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (!(ZERO_EN && r == ZERO_ADDR)) begin
        if (wr_hit[r]) begin
          regs_d[r] = wr_data[r];
          busy_d[r] = 1'b0;
        end
        if (set_en && set_addr == AW'(r)) begin
          busy_d[r] = 1'b1;
        end
      end
    end
  end

  // NOTE: the storage array is reset on purpose: reads after reset must be 0,
  // and non-blocking assignments keep every register updating from old state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;
    logic            is_zero;
    logic            set_match;
    logic [XLEN-1:0] rd;
    logic            bz;

    assign ra        = raddr[j*AW +: AW];
    assign is_zero   = ZERO_EN && (ra == AW'(ZERO_ADDR));
    assign set_match = set_en && (set_addr == ra);

    regfile_wr_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
      .addr_i  (ra),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .hit_o   (byp_hit),
      .data_o  (byp_data)
    );

    always_comb begin
      rd = regs_q[ra];
      bz = busy_q[ra];
      if (BYP_EN && byp_hit) begin
        rd = byp_data;
        if (!set_match) bz = 1'b0;
      end
      if (is_zero) begin
        rd = '0;
        bz = 1'b0;
      end
    end

    assign rdata[j*XLEN +: XLEN] = rd;
    assign rbusy[j]              = bz;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp: bypass, non-bypass and wide configs.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  // Shared stimulus for the 32x32 bypass (dut) and non-bypass (dut_nb) files.
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic        set_en;
  logic [4:0]  set_addr;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;

  // Wide configuration: XLEN=64, NREGS=16, NRD=4, NWR=2.
  logic [1:0]   w_we;
  logic [7:0]   w_waddr;
  logic [127:0] w_wdata;
  logic [15:0]  w_raddr;
  logic         w_set_en;
  logic [3:0]   w_set_addr;
  logic [255:0] w_rdata;
  logic [3:0]   w_rbusy;

  regfile_mp #(.NWR(2), .BYPASS(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .set_en(set_en), .set_addr(set_addr)
  );

  regfile_mp #(.NWR(2), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Rst_n(Rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .set_en(set_en), .set_addr(set_addr)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(2)) dut_w (
    .Clk(Clk), .Rst_n(Rst_n), .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
    .raddr(w_raddr), .rdata(w_rdata), .rbusy(w_rbusy),
    .set_en(w_set_en), .set_addr(w_set_addr)
  );

  typedef struct {
    string       name;
    int          sel;
    int          port;
    logic [63:0] data;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  function automatic xword_t val(int r);
    return 32'h1000_0000 + xword_t'(r) * 32'h111;
  endfunction

  function automatic logic [63:0] wval(int r);
    return 64'hF00D_0000_0000_0000 + 64'(r) * 64'h1_0000_0001;
  endfunction

  task automatic expect_rd(string name, int sel, int port, logic [63:0] d, logic b);
    exp_t e;
    e.name = name; e.sel = sel; e.port = port; e.data = d; e.busy = b;
    sb.push_back(e);
  endtask

  // Push expectations for one read port of both narrow files.
  task automatic expect2(string name, int port, xword_t d_byp, xword_t d_nb,
                         logic b_byp, logic b_nb);
    expect_rd({name, "/byp"}, 0, port, {32'h0, d_byp}, b_byp);
    expect_rd({name, "/nb"},  1, port, {32'h0, d_nb},  b_nb);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  always @(negedge Clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [63:0] act_d;
      logic        act_b;
      e = sb.pop_front();
      case (e.sel)
        0:       begin act_d = {32'h0, rdata_a[e.port*32 +: 32]}; act_b = rbusy_a[e.port]; end
        1:       begin act_d = {32'h0, rdata_b[e.port*32 +: 32]}; act_b = rbusy_b[e.port]; end
        default: begin act_d = w_rdata[e.port*64 +: 64];          act_b = w_rbusy[e.port]; end
      endcase
      vectors++;
      if (act_d !== e.data) begin
        errors++;
        $display("FAIL %s rdata[%0d]: got %h expected %h", e.name, e.port, act_d, e.data);
      end
      vectors++;
      if (act_b !== e.busy) begin
        errors++;
        $display("FAIL %s rbusy[%0d]: got %b expected %b", e.name, e.port, act_b, e.busy);
      end
    end
  end

  // Advance to just after the next rising edge and return all enables to idle.
  task automatic step();
    @(posedge Clk);
    #1;
    we = '0; set_en = 1'b0; w_we = '0; w_set_en = 1'b0;
  endtask

  initial begin
    we = '0; waddr = '0; wdata = '0; raddr = '0; set_en = 1'b0; set_addr = '0;
    w_we = '0; w_waddr = '0; w_wdata = '0; w_raddr = '0; w_set_en = 1'b0; w_set_addr = '0;

    // Reset state.
    raddr = {5'd31, 5'd1};
    expect2("rst0", 0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect2("rst0", 1, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    Rst_n = 1'b1;

    // Preload x1..x31 two per cycle; port1 targeting x0 in the last cycle is dropped.
    for (int r = 1; r < 32; r += 2) begin
      step();
      we    = 2'b11;
      waddr = {5'(r + 1), 5'(r)};
      wdata = {val(r + 1), val(r)};
    end
    step();
    set_en = 1'b1; set_addr = 5'd20;
    raddr  = {5'd20, 5'd3};
    expect2("preload_x3",  0, val(3),  val(3),  1'b0, 1'b0);
    expect2("preload_x20", 1, val(20), val(20), 1'b0, 1'b0);
    step();
    expect2("busy_x20", 1, val(20), val(20), 1'b1, 1'b1);
    step();
    #2;
    Rst_n = 1'b0;
    expect2("async_rst_x3",  0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect2("async_rst_x20", 1, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    Rst_n = 1'b1;

    // Zero register ignores writes and sets.
    step();
    we = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'hDEAD_BEEF; raddr[4:0] = 5'd0;
    expect2("zero_same", 0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    expect2("zero_next", 0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    set_en = 1'b1; set_addr = 5'd0;
    expect2("zero_set", 0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    expect2("zero_set_next", 0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Same-cycle bypass vs. next-cycle visibility.
    step();
    we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hAAAA_0005; raddr = {5'd5, 5'd0};
    expect2("byp_first", 1, 32'hAAAA_0005, 32'h0, 1'b0, 1'b0);
    step();
    we = 2'b01; wdata[31:0] = 32'h1234_5678;
    expect2("byp_x5", 1, 32'h1234_5678, 32'hAAAA_0005, 1'b0, 1'b0);
    step();
    expect2("byp_x5_next", 1, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);

    // Two ports write x7: port1 wins.
    step();
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h2, 32'h1}; raddr = {5'd7, 5'd5};
    expect2("collide_same", 1, 32'h2, 32'h0, 1'b0, 1'b0);
    step();
    expect2("collide_next", 1, 32'h2, 32'h2, 1'b0, 1'b0);

    // Scoreboard on x10 (port0), x11 (port1).
    step();
    set_en = 1'b1; set_addr = 5'd10; raddr = {5'd11, 5'd10};
    expect2("sb_set_t", 0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    expect2("sb_t1", 0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    expect2("sb_t2", 0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    we = 2'b01; waddr[4:0] = 5'd10; wdata[31:0] = 32'h55;
    expect2("sb_wr_t3", 0, 32'h55, 32'h0, 1'b0, 1'b1);
    step();
    expect2("sb_clr_t4", 0, 32'h55, 32'h55, 1'b0, 1'b0);
    step();
    we = 2'b01; wdata[31:0] = 32'h66; set_en = 1'b1; set_addr = 5'd10;
    expect2("sb_setwr_a", 0, 32'h66, 32'h55, 1'b0, 1'b0);
    step();
    we = 2'b01; wdata[31:0] = 32'h77; set_en = 1'b1; set_addr = 5'd10;
    expect2("sb_setwr_b", 0, 32'h77, 32'h66, 1'b1, 1'b1);
    step();
    expect2("sb_set_wins", 0, 32'h77, 32'h77, 1'b1, 1'b1);
    step();
    we = 2'b10; waddr[9:5] = 5'd10; wdata[63:32] = 32'h88; set_en = 1'b1; set_addr = 5'd11;
    expect2("sb_wr_p1", 0, 32'h88, 32'h77, 1'b0, 1'b1);
    expect2("sb_set_x11", 1, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    expect2("sb_clr_p1", 0, 32'h88, 32'h88, 1'b0, 1'b0);
    expect2("sb_x11_busy", 1, 32'h0, 32'h0, 1'b1, 1'b1);

    // Wide configuration: fill x1..x15, then read four ports with a bypass on x10.
    for (int r = 0; r < 16; r += 2) begin
      step();
      w_we    = 2'b11;
      w_waddr = {4'(r + 1), 4'(r)};
      w_wdata = {wval(r + 1), wval(r)};
    end
    step();
    w_raddr = {4'd15, 4'd10, 4'd5, 4'd0};
    w_we = 2'b01; w_waddr[3:0] = 4'd10; w_wdata[63:0] = 64'hFFFF_0000_FFFF_0000;
    w_set_en = 1'b1; w_set_addr = 4'd15;
    expect_rd("wide_x0",      2, 0, 64'h0, 1'b0);
    expect_rd("wide_x5",      2, 1, wval(5), 1'b0);
    expect_rd("wide_byp_x10", 2, 2, 64'hFFFF_0000_FFFF_0000, 1'b0);
    expect_rd("wide_x15",     2, 3, wval(15), 1'b0);
    step();
    expect_rd("wide_x10_next", 2, 2, 64'hFFFF_0000_FFFF_0000, 1'b0);
    expect_rd("wide_x15_busy", 2, 3, wval(15), 1'b1);

    @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
